// File: rtl/inst_fetch_buffer_if.sv
// Fetch-buffer bus: redirect input, instruction-memory request/ack port,
// and the valid/ready instruction stream toward decode.
interface inst_fetch_buffer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport slave (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst, inst_pc
    );

    modport master (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Request/ack instruction fetch engine feeding a small FIFO toward decode.
// Optional FETCH_BYPASS_EN: an ack into an empty FIFO is presented in the same cycle.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic                  i_clk,
    input logic                  i_reset,
    inst_fetch_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t           r_state;
    logic [31:0]      r_fetch_pc;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_imem_req;
    logic [31:0]      r_imem_addr;
    entry_t           r_mem [DEPTH];

    state_t           w_state_next;
    logic [31:0]      w_fetch_pc_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_push;
    logic             w_pop;
    logic             w_ack;
    logic             w_head_valid;
    logic             w_byp_take;

    assign w_ack        = r_imem_req & bus.imem_ack;
    assign w_head_valid = (r_count != '0);

`ifdef FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp          = ~w_head_valid & (r_state == S_FETCH) & w_ack & ~bus.redirect_valid;
    assign w_byp_take     = w_byp & bus.inst_ready;
    assign bus.inst_valid = w_head_valid | w_byp;
    assign bus.inst       = w_byp ? bus.imem_rdata : r_mem[r_rptr].inst;
    assign bus.inst_pc    = w_byp ? r_fetch_pc     : r_mem[r_rptr].pc;
`else
    assign w_byp_take     = 1'b0;
    assign bus.inst_valid = w_head_valid;
    assign bus.inst       = r_mem[r_rptr].inst;
    assign bus.inst_pc    = r_mem[r_rptr].pc;
`endif

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_imem_addr;

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_count_next    = r_count;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        if (bus.redirect_valid) begin
            // Flush wins over push/pop; an unacked request must drain before refetch.
            w_count_next    = '0;
            w_fetch_pc_next = bus.redirect_pc;
            if (r_state == S_DISCARD)
                w_state_next = w_ack ? S_FETCH : S_DISCARD;
            else if (r_imem_req && !bus.imem_ack)
                w_state_next = S_DISCARD;
            else
                w_state_next = S_FETCH;
        end else begin
            w_pop = w_head_valid & bus.inst_ready;
            case (r_state)
                S_FETCH: begin
                    if (w_ack) begin
                        w_push          = ~w_byp_take;
                        w_fetch_pc_next = r_fetch_pc + 32'd4;
                    end
                end
                S_DISCARD: begin
                    if (w_ack) w_state_next = S_FETCH;
                end
                default: ;
            endcase
            w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (r_state != S_DISCARD)
                w_state_next = (w_count_next == FULL) ? S_HOLD : S_FETCH;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_FETCH;
            r_fetch_pc  <= RESET_PC;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_count    <= w_count_next;
            if (bus.redirect_valid) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
            // Request is held through DISCARD so the address never changes mid-request.
            r_imem_req <= (w_state_next != S_HOLD);
            if (w_state_next == S_FETCH)
                r_imem_addr <= w_fetch_pc_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= '{pc: r_fetch_pc, inst: bus.imem_rdata};
    end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: streaming table plus hand sequences for
// backpressure, redirect while pending, redirect on ack, and mid-request reset.
module tb_inst_fetch_buffer;
    localparam logic [31:0] PAT = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic zw = 1'b1;
    logic man_ack = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    inst_fetch_buffer_if ifc ();

    assign ifc.imem_ack   = zw ? ifc.imem_req : man_ack;
    assign ifc.imem_rdata = ifc.imem_addr ^ PAT;

    inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (ifc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic        chk_inst;
        logic [31:0] pc;
        logic [31:0] inst;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic zero_wait, input logic ready);
        reset = 1'b0;
        zw = zero_wait;
        man_ack = 1'b0;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 32'h0;
        ifc.inst_ready = ready;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int acks;
        ifc.redirect_valid = 1'b0;
        ifc.redirect_pc = 32'h0;
        ifc.inst_ready = 1'b1;

        tbl[0] = '{req: 1'b1, addr: 32'h0, vld: 1'b0, chk_inst: 1'b0, pc: 32'h0, inst: 32'h0};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{req: 1'b1, addr: 32'(4*i), vld: 1'b1, chk_inst: 1'b1,
                       pc: 32'(4*(i-1)), inst: 32'(4*(i-1)) ^ PAT};

`ifndef FETCH_BYPASS_EN
        // Streaming with zero-wait memory
        do_reset(1'b1, 1'b1);
        chk("rst_req", 32'(ifc.imem_req), 32'h0);
        chk("rst_addr", ifc.imem_addr, 32'h0);
        chk("rst_valid", 32'(ifc.inst_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("stream%0d_req", i), 32'(ifc.imem_req), 32'(tbl[i].req));
            chk($sformatf("stream%0d_addr", i), ifc.imem_addr, tbl[i].addr);
            chk($sformatf("stream%0d_valid", i), 32'(ifc.inst_valid), 32'(tbl[i].vld));
            if (tbl[i].chk_inst) begin
                chk($sformatf("stream%0d_pc", i), ifc.inst_pc, tbl[i].pc);
                chk($sformatf("stream%0d_inst", i), ifc.inst, tbl[i].inst);
            end
        end

        // Backpressure fills the FIFO then holds
        do_reset(1'b1, 1'b0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.imem_req && ifc.imem_ack) acks++;
            tick();
        end
        chk("full_acks", 32'(acks), 32'd4);
        chk("full_req", 32'(ifc.imem_req), 32'h0);
        chk("full_pc", ifc.inst_pc, 32'h0);
        chk("full_valid", 32'(ifc.inst_valid), 32'h1);
        ifc.inst_ready = 1'b1;
        tick();
        chk("resume_req", 32'(ifc.imem_req), 32'h1);
        chk("resume_addr", ifc.imem_addr, 32'h10);
        chk("resume_pc", ifc.inst_pc, 32'h4);

        // Redirect while request to 0x8 is pending, ack delayed 3 cycles
        do_reset(1'b0, 1'b1);
        tick();
        chk("rd_req0", 32'(ifc.imem_req), 32'h1);
        man_ack = 1'b1;
        tick();
        chk("rd_addr4", ifc.imem_addr, 32'h4);
        tick();
        chk("rd_addr8", ifc.imem_addr, 32'h8);
        chk("rd_pc4", ifc.inst_pc, 32'h4);
        man_ack = 1'b0;
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h100;
        tick();
        ifc.redirect_valid = 1'b0;
        chk("rd_hold_req", 32'(ifc.imem_req), 32'h1);
        chk("rd_hold_addr", ifc.imem_addr, 32'h8);
        chk("rd_flush_valid", 32'(ifc.inst_valid), 32'h0);
        tick();
        chk("rd_wait1_valid", 32'(ifc.inst_valid), 32'h0);
        chk("rd_wait1_addr", ifc.imem_addr, 32'h8);
        tick();
        chk("rd_wait2_valid", 32'(ifc.inst_valid), 32'h0);
        man_ack = 1'b1;
        tick();
        chk("rd_new_addr", ifc.imem_addr, 32'h100);
        chk("rd_drop_valid", 32'(ifc.inst_valid), 32'h0);
        tick();
        chk("rd_first_valid", 32'(ifc.inst_valid), 32'h1);
        chk("rd_first_pc", ifc.inst_pc, 32'h100);
        chk("rd_first_inst", ifc.inst, 32'h100 ^ PAT);

        // Redirect on the same edge as an ack, two entries buffered
        do_reset(1'b0, 1'b0);
        tick();
        man_ack = 1'b1;
        tick();
        tick();
        chk("ra_addr8", ifc.imem_addr, 32'h8);
        chk("ra_pc0", ifc.inst_pc, 32'h0);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h200;
        tick();
        ifc.redirect_valid = 1'b0;
        chk("ra_req", 32'(ifc.imem_req), 32'h1);
        chk("ra_addr", ifc.imem_addr, 32'h200);
        chk("ra_valid", 32'(ifc.inst_valid), 32'h0);
        ifc.inst_ready = 1'b1;
        tick();
        chk("ra_first_valid", 32'(ifc.inst_valid), 32'h1);
        chk("ra_first_pc", ifc.inst_pc, 32'h200);

        // Reset pulse while a request is pending
        man_ack = 1'b0;
        tick();
        chk("mr_pend_req", 32'(ifc.imem_req), 32'h1);
        chk("mr_pend_addr", ifc.imem_addr, 32'h204);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mr_req", 32'(ifc.imem_req), 32'h0);
        chk("mr_addr", ifc.imem_addr, 32'h0);
        chk("mr_valid", 32'(ifc.inst_valid), 32'h0);
        tick();
        chk("mr_restart_req", 32'(ifc.imem_req), 32'h1);
        chk("mr_restart_addr", ifc.imem_addr, 32'h0);
`else
        // Same-cycle bypass into an empty FIFO
        do_reset(1'b0, 1'b1);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc = 32'h40;
        tick();
        ifc.redirect_valid = 1'b0;
        chk("byp_addr", ifc.imem_addr, 32'h40);
        chk("byp_idle_valid", 32'(ifc.inst_valid), 32'h0);
        man_ack = 1'b1;
        #1;
        chk("byp_valid", 32'(ifc.inst_valid), 32'h1);
        chk("byp_pc", ifc.inst_pc, 32'h40);
        chk("byp_inst", ifc.inst, 32'h40 ^ PAT);
        tick();
        man_ack = 1'b0;
        #1;
        chk("byp_empty", 32'(ifc.inst_valid), 32'h0);
        chk("byp_next_addr", ifc.imem_addr, 32'h44);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
